motor_ramp_ctrl: RTL and testbench

//  Sequences the PWM motor datapath. Takes 8-bit motor commands from the SPI

---
 rtl/motor_ramp_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_motor_ramp_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_ramp_ctrl.sv
// Purpose  : sequences the PWM motor datapath by slewing the duty nybble toward a commanded target, with dead time on reversal and a brake override.
// Latency  : a command is registered on the cmd_valid edge, and the FSM acts on it one cycle later; each duty step takes RAMP_TICKS cycles.
// Backpress: none; commands are always accepted, and the last write wins.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   cmd_valid  1-cycle strobe qualifying cmd
//   cmd        [3:0] target duty, [4] dir (1=CW), [5] brake, [7:6] ignored
//   duty       4-bit duty nybble to the PWM generator
//   dir        direction currently driven
//   drive_en   1 = motor pins may be driven by PWM
//   brake      1 = brake asserted
//   busy       1 = outputs have not yet reached the commanded target
//   state      FSM state: IDLE=0, RUN=1, DEAD=2, BRAKE=3
module motor_ramp_ctrl #(
  parameter int unsigned RAMP_TICKS = 1_000_000,
  parameter int unsigned DEAD_TICKS = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd,
  output logic [3:0] duty,
  output logic       dir,
  output logic       drive_en,
  output logic       brake,
  output logic       busy,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DEAD  = 2'd2,
    ST_BRAKE = 2'd3
  } state_e;

  localparam logic [31:0] RAMP_LAST = 32'(RAMP_TICKS - 1);
  localparam logic [31:0] DEAD_LAST = 32'(DEAD_TICKS - 1);

  // Registered command target
  logic [3:0]  tgt_duty_q;
  logic        tgt_dir_q;
  logic        tgt_brake_q;

  // FSM and datapath registers
  state_e      state_q,    state_d;
  logic [3:0]  duty_q,     duty_d;
  logic        dir_q,      dir_d;
  logic        drive_en_q, drive_en_d;
  logic        brake_q,    brake_d;
  logic [31:0] step_cnt_q, step_cnt_d;
  logic [31:0] dead_cnt_q, dead_cnt_d;

  // A direction mismatch while running means ramp down to zero before reversing.
  logic        dir_flip;
  logic [3:0]  goal;

  // The top two command bits carry no meaning for this block.
  logic        unused_cmd_bits;
  assign unused_cmd_bits = ^cmd[7:6];

  assign dir_flip = (tgt_dir_q != dir_q);
  assign goal     = dir_flip ? 4'd0 : tgt_duty_q;

  // ------------------------------------------------------------------
  // Command capture
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_duty_q  <= 4'd0;
      tgt_dir_q   <= 1'b0;
      tgt_brake_q <= 1'b0;
    end else if (cmd_valid) begin
      tgt_duty_q  <= cmd[3:0];
      tgt_dir_q   <= cmd[4];
      tgt_brake_q <= cmd[5];
    end
  end

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      duty_q     <= 4'd0;
      dir_q      <= 1'b0;
      drive_en_q <= 1'b0;
      brake_q    <= 1'b0;
      step_cnt_q <= 32'd0;
      dead_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      drive_en_q <= drive_en_d;
      brake_q    <= brake_d;
      step_cnt_q <= step_cnt_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state and datapath logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    drive_en_d = drive_en_q;
    brake_d    = brake_q;
    step_cnt_d = step_cnt_q;
    dead_cnt_d = dead_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        duty_d     = 4'd0;
        drive_en_d = 1'b0;
        brake_d    = 1'b0;
        if (tgt_brake_q) begin
          state_d = ST_BRAKE;
          brake_d = 1'b1;
        end else if (tgt_duty_q != 4'd0) begin
          state_d    = ST_RUN;
          dir_d      = tgt_dir_q;
          drive_en_d = 1'b1;
          step_cnt_d = 32'd0;
        end
      end

      ST_RUN: begin
        if (tgt_brake_q) begin
          state_d    = ST_BRAKE;
          duty_d     = 4'd0;
          drive_en_d = 1'b0;
          brake_d    = 1'b1;
          step_cnt_d = 32'd0;
        end else if (duty_q == goal) begin
          // Settled: the timer rests at zero so the next step is a full period away.
          step_cnt_d = 32'd0;
          if (duty_q == 4'd0) begin
            // Zero duty with a matching direction means a zero command: stop without dead time.
            drive_en_d = 1'b0;
            if (dir_flip) begin
              state_d    = ST_DEAD;
              dead_cnt_d = 32'd0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else if (step_cnt_q == RAMP_LAST) begin
          step_cnt_d = 32'd0;
          duty_d     = (duty_q < goal) ? duty_q + 4'd1 : duty_q - 4'd1;
        end else begin
          step_cnt_d = step_cnt_q + 32'd1;
        end
      end

      ST_DEAD: begin
        duty_d     = 4'd0;
        drive_en_d = 1'b0;
        if (tgt_brake_q) begin
          state_d = ST_BRAKE;
          brake_d = 1'b1;
        end else if (dead_cnt_q == DEAD_LAST) begin
          state_d    = ST_IDLE;
          dead_cnt_d = 32'd0;
        end else begin
          dead_cnt_d = dead_cnt_q + 32'd1;
        end
      end

      ST_BRAKE: begin
        duty_d     = 4'd0;
        drive_en_d = 1'b0;
        brake_d    = 1'b1;
        // Releasing the brake always costs a full dead time before driving again.
        if (!tgt_brake_q) begin
          state_d    = ST_DEAD;
          brake_d    = 1'b0;
          dead_cnt_d = 32'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign duty     = duty_q;
  assign dir      = dir_q;
  assign drive_en = drive_en_q;
  assign brake    = brake_q;
  assign state    = state_q;

  assign busy = (state_q == ST_DEAD)
             || ((state_q == ST_RUN)  && ((duty_q != tgt_duty_q) || dir_flip))
             || ((state_q == ST_IDLE) && (tgt_duty_q != 4'd0) && !tgt_brake_q);

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
module tb_motor_ramp_ctrl;

  localparam int RAMP = 4;
  localparam int DEAD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic [3:0] duty;
  logic       dir;
  logic       drive_en;
  logic       brake;
  logic       busy;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  motor_ramp_ctrl #(.RAMP_TICKS(RAMP), .DEAD_TICKS(DEAD)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .duty     (duty),
    .dir      (dir),
    .drive_en (drive_en),
    .brake    (brake),
    .busy     (busy),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Reference model: phase code (0 idle, 1 run, 2 dead, 3 brake), plus a timer counting
  // cycles since the last duty step (run) or since the coast began (dead).
  int m_phase, m_duty, m_dir, m_en, m_brk, m_timer;
  int m_tgt_duty, m_tgt_dir, m_tgt_brk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [7:0] c);
    int goal;
    if (r) begin
      m_phase = 0; m_duty = 0; m_dir = 0; m_en = 0; m_brk = 0; m_timer = 0;
      m_tgt_duty = 0; m_tgt_dir = 0; m_tgt_brk = 0;
      return;
    end
    case (m_phase)
      0: begin
        if (m_tgt_brk != 0) begin
          m_phase = 3; m_brk = 1;
        end else if (m_tgt_duty != 0) begin
          m_phase = 1; m_dir = m_tgt_dir; m_en = 1; m_timer = 0;
        end
      end
      1: begin
        if (m_tgt_brk != 0) begin
          m_phase = 3; m_duty = 0; m_en = 0; m_brk = 1;
        end else begin
          goal = (m_tgt_dir != m_dir) ? 0 : m_tgt_duty;
          if (m_duty == goal) begin
            m_timer = 0;
            if (m_duty == 0) begin
              m_en = 0;
              m_phase = (m_tgt_dir != m_dir) ? 2 : 0;
            end
          end else begin
            m_timer++;
            if (m_timer == RAMP) begin
              m_timer = 0;
              m_duty += (goal > m_duty) ? 1 : -1;
            end
          end
        end
      end
      2: begin
        if (m_tgt_brk != 0) begin
          m_phase = 3; m_brk = 1;
        end else begin
          m_timer++;
          if (m_timer == DEAD) m_phase = 0;
        end
      end
      default: begin
        if (m_tgt_brk == 0) begin
          m_phase = 2; m_brk = 0; m_timer = 0;
        end
      end
    endcase
    if (v) begin
      m_tgt_duty = int'(c[3:0]);
      m_tgt_dir  = int'(c[4]);
      m_tgt_brk  = int'(c[5]);
    end
  endtask

  task automatic compare_model();
    int exp_busy;
    exp_busy = ((m_phase == 2)
             || (m_phase == 1 && (m_duty != m_tgt_duty || m_dir != m_tgt_dir))
             || (m_phase == 0 && m_tgt_duty != 0 && m_tgt_brk == 0)) ? 1 : 0;
    check_eq("duty",     32'(duty),     32'(m_duty));
    check_eq("dir",      32'(dir),      32'(m_dir));
    check_eq("drive_en", 32'(drive_en), 32'(m_en));
    check_eq("brake",    32'(brake),    32'(m_brk));
    check_eq("state",    32'(state),    32'(m_phase));
    check_eq("busy",     32'(busy),     32'(exp_busy));
  endtask

  // One clock: drive inputs, let the edge happen, step the model, compare just after.
  task automatic cycle(input logic r, input logic v, input logic [7:0] c);
    rst = r; cmd_valid = v; cmd = c;
    @(posedge clk);
    model_step(r, v, c);
    #1;
    compare_model();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic       seen_dead;
    logic       en_dropped;
    logic [7:0] c;
    int         exp_duty;

    rst = 1'b1; cmd_valid = 1'b0; cmd = 8'h00;
    m_phase = 0; m_duty = 0; m_dir = 0; m_en = 0; m_brk = 0; m_timer = 0;
    m_tgt_duty = 0; m_tgt_dir = 0; m_tgt_brk = 0;

    // Reset state
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h2F);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_busy",  32'(busy),  32'd0);
    check_eq("rst_brake", 32'(brake), 32'd0);

    // T1: ramp-up timing from a 0x05 command captured at edge 0
    cycle(1'b0, 1'b1, 8'h05);
    check_eq("t1_e0_state", 32'(state), 32'd0);
    check_eq("t1_e0_busy",  32'(busy),  32'd1);
    for (int k = 1; k <= 24; k++) begin
      cycle(1'b0, 1'b0, 8'h00);
      exp_duty = ((k - 1) / RAMP > 5) ? 5 : (k - 1) / RAMP;
      check_eq("t1_duty", 32'(duty), 32'(exp_duty));
      check_eq("t1_busy", 32'(busy), (k < 21) ? 32'd1 : 32'd0);
      if (k == 1) begin
        check_eq("t1_e1_state", 32'(state),    32'd1);
        check_eq("t1_e1_en",    32'(drive_en), 32'd1);
        check_eq("t1_e1_dir",   32'(dir),      32'd0);
      end
    end

    // T2: reversal CCW 5 -> CW 3 through dead time
    cycle(1'b0, 1'b1, 8'h13);
    seen_dead = 1'b0; en_dropped = 1'b0;
    for (int i = 0; i < 70; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      if (state == 2'd2) seen_dead = 1'b1;
      if (!seen_dead && !drive_en) en_dropped = 1'b1;
    end
    check_eq("t2_seen_dead",  32'(seen_dead),  32'd1);
    check_eq("t2_en_dropped", 32'(en_dropped), 32'd0);
    check_eq("t2_dir",        32'(dir),        32'd1);
    check_eq("t2_duty",       32'(duty),       32'd3);

    // T3: brake during a ramp, then release to CCW 7
    cycle(1'b0, 1'b1, 8'h1F);
    idle(6);
    cycle(1'b0, 1'b1, 8'h2F);
    cycle(1'b0, 1'b0, 8'h00);
    check_eq("t3_state", 32'(state),    32'd3);
    check_eq("t3_brake", 32'(brake),    32'd1);
    check_eq("t3_duty",  32'(duty),     32'd0);
    check_eq("t3_en",    32'(drive_en), 32'd0);
    cycle(1'b0, 1'b1, 8'h07);
    idle(60);
    check_eq("t3_final_state", 32'(state), 32'd1);
    check_eq("t3_final_duty",  32'(duty),  32'd7);
    check_eq("t3_final_dir",   32'(dir),   32'd0);

    // T4: same-direction decrease 15 -> 2 keeps driving
    cycle(1'b0, 1'b1, 8'h0F);
    idle(40);
    check_eq("t4_peak", 32'(duty), 32'd15);
    cycle(1'b0, 1'b1, 8'h02);
    seen_dead = 1'b0; en_dropped = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      if (state == 2'd2) seen_dead = 1'b1;
      if (!drive_en) en_dropped = 1'b1;
    end
    check_eq("t4_no_dead", 32'(seen_dead),  32'd0);
    check_eq("t4_en_held", 32'(en_dropped), 32'd0);
    check_eq("t4_duty",    32'(duty),       32'd2);

    // T5: zero command returns to idle without dead time
    cycle(1'b0, 1'b1, 8'h03);
    idle(10);
    cycle(1'b0, 1'b1, 8'h00);
    seen_dead = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      if (state == 2'd2) seen_dead = 1'b1;
    end
    check_eq("t5_no_dead", 32'(seen_dead), 32'd0);
    check_eq("t5_state",   32'(state),     32'd0);
    check_eq("t5_en",      32'(drive_en),  32'd0);

    // T6: reset in the middle of a dead time
    cycle(1'b0, 1'b1, 8'h02);
    idle(12);
    cycle(1'b0, 1'b1, 8'h12);
    seen_dead = 1'b0;
    for (int i = 0; i < 30 && !seen_dead; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      if (state == 2'd2) seen_dead = 1'b1;
    end
    check_eq("t6_reached_dead", 32'(seen_dead), 32'd1);
    idle(2);
    cycle(1'b1, 1'b0, 8'h00);
    check_eq("t6_rst_state", 32'(state), 32'd0);
    check_eq("t6_rst_outs",  32'({duty, dir, drive_en, brake, busy}), 32'd0);
    en_dropped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      if (state != 2'd0 || drive_en || duty != 4'd0) en_dropped = 1'b1;
    end
    check_eq("t6_quiet", 32'(en_dropped), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      c = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) != 0) c[5] = 1'b0;
      cycle(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
